// File: rtl/dsp_result_reader.sv
// dsp_result_reader: captures the MULTALU product buses after a settle
// delay. It then streams the snapshot out as bytes over valid/ready and ends
// the stream with a byte that makes the stream's modulo-256 sum zero.
module dsp_result_reader #(
  parameter int NUM_WORDS     = 5,
  parameter int WORD_W        = 64,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [NUM_WORDS*WORD_W-1:0] products,
  output logic [7:0]                  m_data,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic                        busy,
  output logic                        done,
  output logic [7:0]                  checksum
);

  localparam int NUM_BYTES = NUM_WORDS * WORD_W / 8;
  localparam int IDX_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_BYTES - 1);
  localparam logic [7:0]       SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SETTLE  = 3'd1;
  localparam logic [2:0] S_CAPTURE = 3'd2;
  localparam logic [2:0] S_SEND    = 3'd3;
  localparam logic [2:0] S_SUM     = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  logic [2:0]       state;
  logic [7:0]       settle_cnt;
  logic [IDX_W-1:0] idx;
  logic [7:0]       run_sum;
  logic [7:0]       snap [NUM_BYTES];

  // Snapshot register: loads all product bytes in the single CAPTURE cycle.
  // NOTE: the snapshot is a data store and has no reset. m_valid gates every
  // read of it, and every byte is rewritten before the first read.
  always_ff @(posedge clk) begin
    if (state == S_CAPTURE) begin
      for (int i = 0; i < NUM_BYTES; i++) begin
        snap[i] <= products[8*i +: 8];
      end
    end
  end

  // Sequencer: settle delay, capture, byte stream, checksum byte, done.
  // NOTE: sequential state is assigned with non-blocking (<=) only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      settle_cnt <= '0;
      idx        <= '0;
      run_sum    <= '0;
      checksum   <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state      <= S_SETTLE;
            settle_cnt <= SETTLE_LOAD;
          end
        end
        S_SETTLE: begin
          if (settle_cnt == 8'd0) state <= S_CAPTURE;
          else                    settle_cnt <= settle_cnt - 8'd1;
        end
        S_CAPTURE: begin
          idx     <= '0;
          run_sum <= '0;
          state   <= S_SEND;
        end
        S_SEND: begin
          if (m_ready) begin
            run_sum <= run_sum + m_data;
            if (idx == LAST_IDX) state <= S_SUM;
            else                 idx   <= idx + 1'b1;
          end
        end
        S_SUM: begin
          if (m_ready) begin
            checksum <= m_data;
            state    <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Output decode. Outputs come straight from the registered state, so they
  // hold stable during a stall without any extra storage.
  // NOTE: m_data gets a default before the case, so this block infers no latch.
  always_comb begin
    m_data = 8'h00;
    case (state)
      S_SEND:  m_data = snap[idx];
      S_SUM:   m_data = 8'h00 - run_sum;
      default: m_data = 8'h00;
    endcase
  end

  assign m_valid = (state == S_SEND) || (state == S_SUM);
  assign busy    = (state != S_IDLE) && (state != S_DONE);
  assign done    = (state == S_DONE);

endmodule

// File: tb/tb_dsp_result_reader.sv
// Directed testbench for dsp_result_reader with the default parameters
// (5 x 64-bit words, 40 data bytes plus 1 checksum byte, settle of 4).
module tb_dsp_result_reader;

  localparam int NW = 5;
  localparam int WW = 64;
  localparam int NB = NW * WW / 8;

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic [NW*WW-1:0] products;
  logic [7:0]      m_data;
  logic            m_valid;
  logic            m_ready;
  logic            busy;
  logic            done;
  logic [7:0]      checksum;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] got [64];
  logic [7:0] lfsr = 8'hA5;

  dsp_result_reader #(.NUM_WORDS(NW), .WORD_W(WW), .SETTLE_CYCLES(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .products (products),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .busy     (busy),
    .done     (done),
    .checksum (checksum)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample and drive 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Accept bytes until done (or until stop_after bytes have been taken).
  // With bp set, m_ready follows an LFSR pattern, capped at 5 stall cycles.
  task automatic run_stream(input bit bp, input int start_at, input int stop_after,
                            output int n, output int cycles);
    logic [7:0] held;
    bit         stalled;
    int         stall_run;
    n = 0; cycles = 0; stalled = 1'b0; stall_run = 0; held = 8'h00;
    while (!done && n < stop_after && cycles < 2000) begin
      if (bp) begin
        m_ready = lfsr[0] || (stall_run >= 5);
        lfsr    = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      end else begin
        m_ready = 1'b1;
      end
      start = (n == start_at);
      if (m_valid) begin
        if (stalled) check("stall_hold", m_data, held);
        if (m_ready) begin
          if (n < 64) got[n] = m_data;
          n++;
          stalled   = 1'b0;
          stall_run = 0;
        end else begin
          stalled = 1'b1;
          held    = m_data;
          stall_run++;
        end
      end
      tick();
      cycles++;
    end
    start   = 1'b0;
    m_ready = 1'b0;
    if (cycles >= 2000) check("stream_timeout", 32'(cycles), 32'd0);
  endtask

  task automatic verify(input string name, input logic [NW*WW-1:0] snap,
                        input logic [7:0] exp_ck, input int n);
    logic [NW*WW-1:0] s;
    int               bad;
    s   = snap;
    bad = -1;
    check({name, "_count"}, 32'(n), 32'(NB + 1));
    for (int i = 0; i < NB; i++) begin
      if (bad < 0 && got[i] !== s[8*i +: 8]) bad = i;
    end
    if (bad >= 0) check({name, "_byte"}, {24'h0, got[bad]}, {24'h0, s[8*bad +: 8]});
    else          check({name, "_bytes"}, {24'h0, got[NB-1]}, {24'h0, s[8*(NB-1) +: 8]});
    check({name, "_ckbyte"}, {24'h0, got[NB]}, {24'h0, exp_ck});
    check({name, "_checksum"}, {24'h0, checksum}, {24'h0, exp_ck});
    check({name, "_done"}, {29'h0, done, busy, m_valid}, 32'b100);
  endtask

  initial begin
    int n;
    int cyc;
    int lat;
    logic [NW*WW-1:0] snap;

    reset = 1'b1; start = 1'b0; m_ready = 1'b0; products = '0;
    tick(); tick();
    reset = 1'b0;
    tick();
    check("reset_outputs", {19'h0, m_data, m_valid, busy, done}, 32'h0);
    check("reset_checksum", {24'h0, checksum}, 32'h0);

    // Basic stream: bytes 0x13, 0xC3; checksum 0x2A; 47-cycle start-to-done.
    products = '0;
    products[0 +: 64]  = 64'h13;
    products[64 +: 64] = 64'hC3;
    snap = products;
    pulse_start();
    check("busy_after_start", {31'h0, busy}, 32'd1);
    run_stream(1'b0, -1, 1000, n, cyc);
    verify("basic", snap, 8'h2A, n);
    check("basic_latency", 32'(cyc + 1), 32'd47);

    // Settle/snapshot timing: the value present in CAPTURE is what streams.
    products = '0;
    products[0 +: 64] = 64'h11;
    pulse_start();
    tick(); tick();
    products[0 +: 64] = 64'h22;
    lat = 2;
    while (!m_valid && lat < 50) begin
      tick();
      lat++;
    end
    products[0 +: 64] = 64'h33;
    check("first_valid_cycle", 32'(lat), 32'd5);
    check("first_byte", {24'h0, m_data}, 32'h22);
    snap = '0;
    snap[0 +: 64] = 64'h22;
    run_stream(1'b0, -1, 1000, n, cyc);
    verify("snapshot", snap, 8'hDE, n);

    // Backpressure: bytes 01..08 sum to 0x24 -> checksum 0xDC.
    products = '0;
    products[0 +: 64] = 64'h0807060504030201;
    snap = products;
    pulse_start();
    run_stream(1'b1, -1, 1000, n, cyc);
    verify("backpressure", snap, 8'hDC, n);

    // Start during SEND is ignored; start in DONE relaunches the same stream.
    products = '0;
    products[0 +: 64]  = 64'h13;
    products[64 +: 64] = 64'hC3;
    snap = products;
    pulse_start();
    run_stream(1'b0, 20, 1000, n, cyc);
    verify("busy_start", snap, 8'h2A, n);
    pulse_start();
    check("restart_from_done", {30'h0, done, busy}, 32'b01);
    run_stream(1'b0, -1, 1000, n, cyc);
    verify("restart", snap, 8'h2A, n);

    // Reset after byte 10 is accepted abandons the stream and clears checksum.
    pulse_start();
    run_stream(1'b0, -1, 10, n, cyc);
    check("partial_count", 32'(n), 32'd10);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midreset_state", {29'h0, m_valid, busy, done}, 32'b000);
    check("midreset_checksum", {24'h0, checksum}, 32'h0);

    // Reset wins over start in the same cycle; the block stays idle.
    reset = 1'b1; start = 1'b1;
    tick();
    reset = 1'b0; start = 1'b0;
    check("reset_vs_start", {30'h0, busy, m_valid}, 32'b00);
    tick(); tick();
    check("reset_vs_start_idle", {30'h0, busy, done}, 32'b00);

    // All-ones word 4: sum 0x7F8 -> checksum 0x08.
    products = '0;
    products[256 +: 64] = 64'hFFFF_FFFF_FFFF_FFFF;
    snap = products;
    pulse_start();
    run_stream(1'b1, -1, 1000, n, cyc);
    verify("all_ones", snap, 8'h08, n);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
